// File: rtl/ahbl_bus_splitter_n_if.sv
// AHB-Lite splitter bus bundle: upstream master side, fanned-out slave side
// and error statistics.
interface ahbl_bus_splitter_n_if #(
  parameter int NUM_SLAVES = 8
);
  logic                    HSEL;
  logic [31:0]             HADDR;
  logic [1:0]              HTRANS;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [31:0]             HRDATA;
  logic [NUM_SLAVES-1:0]   S_HSEL;
  logic [NUM_SLAVES*32-1:0] S_HRDATA;
  logic [NUM_SLAVES-1:0]   S_HREADYOUT;
  logic [NUM_SLAVES-1:0]   S_HRESP;
  logic [31:0]             ERR_ADDR;
  logic [7:0]              ERR_CNT;

  modport slave (
    input  HSEL, HADDR, HTRANS, HREADY,
    input  S_HRDATA, S_HREADYOUT, S_HRESP,
    output HREADYOUT, HRESP, HRDATA,
    output S_HSEL, ERR_ADDR, ERR_CNT
  );

  modport master (
    output HSEL, HADDR, HTRANS, HREADY,
    output S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HREADYOUT, HRESP, HRDATA,
    input  S_HSEL, ERR_ADDR, ERR_CNT
  );
endinterface

// File: rtl/ahbl_bus_splitter_n.sv
// AHB-Lite address splitter: one master to NUM_SLAVES slaves, with a
// built-in two-cycle ERROR default slave and unmapped-access statistics.
module ahbl_bus_splitter_n #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_MSB   = 31,
  parameter int ADDR_LSB   = 28,
  parameter logic [NUM_SLAVES*(ADDR_MSB-ADDR_LSB+1)-1:0]
    SLAVE_IDS = 32'h9876_5420
) (
  input logic HCLK,
  input logic HRESET,
  ahbl_bus_splitter_n_if.slave bus
);
  localparam int DEC_W = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [DEC_W-1:0]      field;
  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] sel;
  logic                  hit;
  logic                  miss;
  logic                  cap;
  logic                  unused_htrans0;

  assign field = bus.HADDR[ADDR_MSB:ADDR_LSB];
  assign unused_htrans0 = bus.HTRANS[0];

  // First match wins so duplicate IDs still give a one-hot select
  always_comb begin
    match = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && field == SLAVE_IDS[i*DEC_W +: DEC_W]) begin
        match[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

  assign sel        = {NUM_SLAVES{bus.HSEL}} & match;
  assign bus.S_HSEL = sel;
  assign miss       = bus.HSEL & bus.HTRANS[1] & ~hit;
  assign cap        = bus.HREADY;

  always_comb begin
    dsel_d     = dsel_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (cap) begin
      dsel_d = sel & {NUM_SLAVES{bus.HTRANS[1]}};
    end
    if (cap && miss) begin
      err_addr_d = bus.HADDR;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q
                                         : err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cap && miss) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = (cap && miss) ? ERR1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      dsel_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dsel_q     <= dsel_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  logic        rdy;
  logic        rsp;
  logic [31:0] rdata;

  always_comb begin
    rdy   = 1'b1;
    rsp   = 1'b0;
    rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        rdy   = bus.S_HREADYOUT[i];
        rsp   = bus.S_HRESP[i];
        rdata = bus.S_HRDATA[i*32 +: 32];
      end
    end
    unique case (1'b1)
      (state_q == ERR1): begin
        rdy   = 1'b0;
        rsp   = 1'b1;
        rdata = '0;
      end
      (state_q == ERR2): begin
        rdy   = 1'b1;
        rsp   = 1'b1;
        rdata = '0;
      end
      default: ;
    endcase
  end

  assign bus.HREADYOUT = rdy;
  assign bus.HRESP     = rsp;
  assign bus.HRDATA    = rdata;
  assign bus.ERR_ADDR  = err_addr_q;
  assign bus.ERR_CNT   = err_cnt_q;
endmodule

// File: tb/tb_ahbl_bus_splitter_n.sv
// Directed self-checking bench for ahbl_bus_splitter_n with default IDs
// and HREADY looped back from HREADYOUT.
module tb_ahbl_bus_splitter_n;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ahbl_bus_splitter_n_if #(.NUM_SLAVES(8)) bus ();

  ahbl_bus_splitter_n #(
    .NUM_SLAVES(8),
    .ADDR_MSB  (31),
    .ADDR_LSB  (28),
    .SLAVE_IDS (32'h9876_5420)
  ) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus)
  );

  assign bus.HREADY = bus.HREADYOUT;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] a,
                       input logic [1:0] t);
    bus.HSEL   = s;
    bus.HADDR  = a;
    bus.HTRANS = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %0b want 1", bus.HREADYOUT);
    end
    checks++;
    if (bus.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp: got %0b want 0", bus.HRESP);
    end
    checks++;
    if (bus.HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h want 0", bus.HRDATA);
    end
    checks++;
    if (bus.ERR_CNT !== 8'd0 || bus.ERR_ADDR !== 32'h0) begin
      errors++;
      $display("FAIL rst_stats: got cnt %0d addr %h want 0 0",
               bus.ERR_CNT, bus.ERR_ADDR);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    step();
    drive(1'b1, 32'h4000_0010, 2'b10);
    #1;
    checks++;
    if (bus.S_HSEL !== 8'b0000_0100) begin
      errors++;
      $display("FAIL rd_hsel: got %b want 00000100", bus.S_HSEL);
    end
    step();
    drive(1'b1, 32'h4000_0010, 2'b00);
    #1;
    checks++;
    if (bus.HRDATA !== 32'hCAFE_F00D || bus.HREADYOUT !== 1'b1 ||
        bus.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: got %h/%0b/%0b want cafef00d/1/0",
               bus.HRDATA, bus.HREADYOUT, bus.HRESP);
    end
    step();
    checks++;
    if (bus.HRDATA !== 32'h0 || bus.HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle: got %h/%0b want 0/1",
               bus.HRDATA, bus.HREADYOUT);
    end
  endtask

  task automatic test_wait();
    step();
    drive(1'b1, 32'h2000_0000, 2'b10);
    step();
    bus.S_HREADYOUT[1] = 1'b0;
    drive(1'b1, 32'h5000_0000, 2'b10);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.HREADYOUT !== 1'b0 || bus.HRDATA !== 32'hA5A5_0001) begin
        errors++;
        $display("FAIL wait_stall%0d: got %0b/%h want 0/a5a50001",
                 k, bus.HREADYOUT, bus.HRDATA);
      end
      step();
    end
    bus.S_HREADYOUT[1] = 1'b1;
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL wait_done: got %0b/%h want 1/a5a50001",
               bus.HREADYOUT, bus.HRDATA);
    end
    step();
    drive(1'b1, 32'h5000_0000, 2'b00);
    #1;
    checks++;
    if (bus.HRDATA !== 32'hA5A5_0003 || bus.HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL wait_pipe: got %h/%0b want a5a50003/1",
               bus.HRDATA, bus.HREADYOUT);
    end
  endtask

  task automatic test_error();
    step();
    drive(1'b1, 32'hF000_0004, 2'b10);
    #1;
    checks++;
    if (bus.S_HSEL !== 8'h00) begin
      errors++;
      $display("FAIL err_hsel: got %b want 0", bus.S_HSEL);
    end
    step();
    drive(1'b1, 32'hF000_0004, 2'b00);
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin
      errors++;
      $display("FAIL err1: got %0b/%0b want 0/1",
               bus.HREADYOUT, bus.HRESP);
    end
    step();
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1 ||
        bus.HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL err2: got %0b/%0b/%h want 1/1/0",
               bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    checks++;
    if (bus.ERR_ADDR !== 32'hF000_0004 || bus.ERR_CNT !== 8'd1) begin
      errors++;
      $display("FAIL err_stats: got %h/%0d want f0000004/1",
               bus.ERR_ADDR, bus.ERR_CNT);
    end
    step();
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL err_end: got %0b/%0b want 1/0",
               bus.HREADYOUT, bus.HRESP);
    end
  endtask

  task automatic test_no_error();
    drive(1'b1, 32'hF000_0000, 2'b00);
    step();
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 ||
        bus.ERR_CNT !== 8'd1) begin
      errors++;
      $display("FAIL noerr_idle: got %0b/%0b/%0d want 1/0/1",
               bus.HREADYOUT, bus.HRESP, bus.ERR_CNT);
    end
    drive(1'b0, 32'hF000_0000, 2'b10);
    step();
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 ||
        bus.ERR_CNT !== 8'd1) begin
      errors++;
      $display("FAIL noerr_unsel: got %0b/%0b/%0d want 1/0/1",
               bus.HREADYOUT, bus.HRESP, bus.ERR_CNT);
    end
    drive(1'b1, 32'h4000_0000, 2'b00);
    #1;
    checks++;
    if (bus.S_HSEL !== 8'b0000_0100) begin
      errors++;
      $display("FAIL noerr_hsel_idle: got %b want 00000100", bus.S_HSEL);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   cyc;
    logic r;
    step();
    drive(1'b1, 32'h0000_0000, 2'b10);
    step();
    drive(1'b1, 32'h5000_0000, 2'b10);
    #1;
    checks++;
    if (bus.HRDATA !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL b2b_s0: got %h want a5a50000", bus.HRDATA);
    end
    step();
    drive(1'b1, 32'h5000_0000, 2'b00);
    #1;
    checks++;
    if (bus.HRDATA !== 32'hA5A5_0003) begin
      errors++;
      $display("FAIL b2b_s3: got %h want a5a50003", bus.HRDATA);
    end
    drive(1'b1, 32'hF000_0008, 2'b10);
    n   = 0;
    cyc = 0;
    while (n < 300 && cyc < 2000) begin
      @(negedge clk);
      r = bus.HREADYOUT;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
        n++;
        if (n == 100) begin
          checks++;
          if (bus.ERR_CNT !== 8'd101) begin
            errors++;
            $display("FAIL cnt_mid: got %0d want 101", bus.ERR_CNT);
          end
        end
      end
    end
    checks++;
    if (n != 300) begin
      errors++;
      $display("FAIL miss_timeout: got %0d misses want 300", n);
    end
    drive(1'b1, 32'hF000_0008, 2'b00);
    repeat (3) step();
    checks++;
    if (bus.ERR_CNT !== 8'd255 || bus.ERR_ADDR !== 32'hF000_0008) begin
      errors++;
      $display("FAIL cnt_sat: got %0d/%h want 255/f0000008",
               bus.ERR_CNT, bus.ERR_ADDR);
    end
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL sat_end: got %0b/%0b want 1/0",
               bus.HREADYOUT, bus.HRESP);
    end
  endtask

  task automatic test_reset_err1();
    step();
    drive(1'b1, 32'hF000_0000, 2'b10);
    step();
    drive(1'b1, 32'hF000_0000, 2'b00);
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin
      errors++;
      $display("FAIL rerr_err1: got %0b/%0b want 0/1",
               bus.HREADYOUT, bus.HRESP);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 ||
        bus.ERR_CNT !== 8'd0 || bus.ERR_ADDR !== 32'h0) begin
      errors++;
      $display("FAIL rerr_abort: got %0b/%0b/%0d/%h want 1/0/0/0",
               bus.HREADYOUT, bus.HRESP, bus.ERR_CNT, bus.ERR_ADDR);
    end
    #1;
    rst = 1'b0;
    step();
    drive(1'b1, 32'h4000_0000, 2'b10);
    #1;
    checks++;
    if (bus.S_HSEL !== 8'b0000_0100) begin
      errors++;
      $display("FAIL rerr_hsel: got %b want 00000100", bus.S_HSEL);
    end
    step();
    drive(1'b1, 32'h4000_0000, 2'b00);
    #1;
    checks++;
    if (bus.HRDATA !== 32'hCAFE_F00D || bus.HREADYOUT !== 1'b1 ||
        bus.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL rerr_read: got %h/%0b/%0b want cafef00d/1/0",
               bus.HRDATA, bus.HREADYOUT, bus.HRESP);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    drive(1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      bus.S_HRDATA[i*32 +: 32] = 32'hA5A5_0000 + i;
    end
    bus.S_HRDATA[2*32 +: 32] = 32'hCAFE_F00D;
    bus.S_HREADYOUT = '1;
    bus.S_HRESP     = '0;

    test_reset();
    test_read();
    test_wait();
    test_error();
    test_no_error();
    test_back_to_back();
    test_reset_err1();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
